// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register and write-back datapath.
// Latches MEM-stage results, selects and aligns the write-back value,
// suppresses writes to $0, issues exactly one RegWrite pulse per instruction
// across stalls, and exports forwarding copies for the hazard unit.
// Optional build macro WB_COMMIT_COUNT_EN adds a committed-write counter.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic              in_RegWrite,
  input  logic [REG_AW-1:0] in_WriteRegister,
  input  logic [1:0]        in_MemToReg,
  input  logic [2:0]        in_LoadType,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic [DATA_W-1:0] in_MemData,
  input  logic [DATA_W-1:0] in_LinkAddr,
  output logic [REG_AW-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              wb_valid,
  output logic              fwd_RegWrite,
  output logic [REG_AW-1:0] fwd_WriteRegister,
  output logic [DATA_W-1:0] fwd_WriteData
`ifdef WB_COMMIT_COUNT_EN
  ,
  output logic [31:0]       commit_count
`endif
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_LINK = 2'b10
  } wbSrc_e;

  typedef enum logic [2:0] {
    LD_WORD   = 3'b000,
    LD_HALF_S = 3'b001,
    LD_HALF_U = 3'b010,
    LD_BYTE_S = 3'b011,
    LD_BYTE_U = 3'b100
  } loadType_e;

  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [DATA_W-1:0] loadValue;
  logic [DATA_W-1:0] selData;
  logic              captureWrite;

  // Held instruction qualifies for a register write (valid, enabled, not $0).
  logic              heldWrite;
  // Held instruction has already produced its single RegWrite pulse.
  logic              committed;

  // Big-endian load alignment and write-back source selection.
  // NOTE: every signal written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    loadByte  = in_MemData[31:24];
    loadHalf  = in_MemData[31:16];
    loadValue = in_MemData;
    selData   = in_ALUResult;

    case (in_ALUResult[1:0])
      2'd0:    loadByte = in_MemData[31:24];
      2'd1:    loadByte = in_MemData[23:16];
      2'd2:    loadByte = in_MemData[15:8];
      default: loadByte = in_MemData[7:0];
    endcase

    // Offset bit 0 is deliberately ignored: misaligned halfwords are not trapped.
    loadHalf = in_ALUResult[1] ? in_MemData[15:0] : in_MemData[31:16];

    case (in_LoadType)
      LD_HALF_S: loadValue = {{(DATA_W-16){loadHalf[15]}}, loadHalf};
      LD_HALF_U: loadValue = {{(DATA_W-16){1'b0}}, loadHalf};
      LD_BYTE_S: loadValue = {{(DATA_W-8){loadByte[7]}}, loadByte};
      LD_BYTE_U: loadValue = {{(DATA_W-8){1'b0}}, loadByte};
      default:   loadValue = in_MemData;
    endcase

    case (in_MemToReg)
      SRC_MEM:  selData = loadValue;
      SRC_LINK: selData = in_LinkAddr;
      default:  selData = in_ALUResult;
    endcase
  end

  assign captureWrite = in_valid & in_RegWrite & (in_WriteRegister != '0);

  // Pipeline register: Reset > Flush > Stall > capture.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      wb_valid      <= 1'b0;
      heldWrite     <= 1'b0;
      committed     <= 1'b0;
`ifdef WB_COMMIT_COUNT_EN
      commit_count  <= '0;
`endif
    end else begin
`ifdef WB_COMMIT_COUNT_EN
      // Counts the write the register file takes on the negedge being left.
      if (RegWrite) commit_count <= commit_count + 32'd1;
`endif
      if (Flush) begin
        WriteRegister <= '0;
        WriteData     <= '0;
        RegWrite      <= 1'b0;
        wb_valid      <= 1'b0;
        heldWrite     <= 1'b0;
        committed     <= 1'b0;
      end else if (Stall) begin
        // Contents held; the write already happened once, so drop RegWrite.
        RegWrite  <= 1'b0;
        committed <= 1'b1;
      end else begin
        WriteRegister <= in_WriteRegister;
        WriteData     <= selData;
        RegWrite      <= captureWrite;
        wb_valid      <= in_valid;
        heldWrite     <= captureWrite;
        committed     <= 1'b0;
      end
    end
  end

  // Forwarding stays live while a stalled instruction still owns its result.
  assign fwd_RegWrite      = RegWrite | (committed & heldWrite);
  assign fwd_WriteRegister = WriteRegister;
  assign fwd_WriteData     = WriteData;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: vector table, hand-written stall/flush/reset
// sequences and a randomized run against a behavioural model.
module tb_mem_wb_writeback;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        in_valid;
  logic        in_RegWrite;
  logic [4:0]  in_WriteRegister;
  logic [1:0]  in_MemToReg;
  logic [2:0]  in_LoadType;
  logic [31:0] in_ALUResult;
  logic [31:0] in_MemData;
  logic [31:0] in_LinkAddr;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        wb_valid;
  logic        fwd_RegWrite;
  logic [4:0]  fwd_WriteRegister;
  logic [31:0] fwd_WriteData;
`ifdef WB_COMMIT_COUNT_EN
  logic [31:0] commit_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_writeback dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .in_valid          (in_valid),
    .in_RegWrite       (in_RegWrite),
    .in_WriteRegister  (in_WriteRegister),
    .in_MemToReg       (in_MemToReg),
    .in_LoadType       (in_LoadType),
    .in_ALUResult      (in_ALUResult),
    .in_MemData        (in_MemData),
    .in_LinkAddr       (in_LinkAddr),
    .WriteRegister     (WriteRegister),
    .WriteData         (WriteData),
    .RegWrite          (RegWrite),
    .wb_valid          (wb_valid),
    .fwd_RegWrite      (fwd_RegWrite),
    .fwd_WriteRegister (fwd_WriteRegister),
    .fwd_WriteData     (fwd_WriteData)
`ifdef WB_COMMIT_COUNT_EN
    ,
    .commit_count      (commit_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [1:0]  mtr;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] link;
    logic [4:0]  dest;
    logic        valid;
    logic        rw;
    logic [31:0] expData;
    logic        expRw;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] dest,
                       input logic [1:0] mtr, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link);
    in_valid         = v;
    in_RegWrite      = rw;
    in_WriteRegister = dest;
    in_MemToReg      = mtr;
    in_LoadType      = lt;
    in_ALUResult     = alu;
    in_MemData       = mem;
    in_LinkAddr      = link;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".RegWrite"}, RegWrite, 0);
    check({tag, ".wb_valid"}, wb_valid, 0);
    check({tag, ".WriteData"}, WriteData, 0);
    check({tag, ".WriteRegister"}, WriteRegister, 0);
    check({tag, ".fwd_RegWrite"}, fwd_RegWrite, 0);
`ifdef WB_COMMIT_COUNT_EN
    check({tag, ".commit_count"}, commit_count, 0);
`endif
  endtask

  // Reference write-back value from the load/source rules using plain arithmetic.
  function automatic logic [31:0] refData(input logic [1:0] mtr, input logic [2:0] lt,
                                          input logic [31:0] alu, input logic [31:0] mem,
                                          input logic [31:0] link);
    int unsigned b;
    int unsigned h;
    int unsigned off;
    if (mtr == 2'd2) return link;
    if (mtr != 2'd1) return alu;
    off = int'(alu[1:0]);
    b = (mem >> (8 * (3 - off))) & 32'hFF;
    h = (mem >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
    case (lt)
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      default: return mem;
    endcase
  endfunction

  // Behavioural model for the random run.
  logic        mValid;
  logic [4:0]  mDest;
  logic [31:0] mData;
  logic        mWant;
  int          mHeld;
  int unsigned mCount;

  initial begin
    Reset = 1'b1;
    Stall = 1'b0;
    Flush = 1'b0;
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #12;
    checkAllZero("reset");
    Reset = 1'b0;

    // ---------------- Vector table ----------------
    vecs[0]  = '{"alu",        2'd0, 3'd0, 32'h12345678, 32'h80FF7F01, 32'h0,        5'd8,  1, 1, 32'h12345678, 1};
    vecs[1]  = '{"lb_off0",    2'd1, 3'd3, 32'h00001000, 32'h80FF7F01, 32'h0,        5'd3,  1, 1, 32'hFFFFFF80, 1};
    vecs[2]  = '{"lbu_off0",   2'd1, 3'd4, 32'h00001000, 32'h80FF7F01, 32'h0,        5'd4,  1, 1, 32'h00000080, 1};
    vecs[3]  = '{"lh_off2",    2'd1, 3'd1, 32'h00001002, 32'h80FF7F01, 32'h0,        5'd5,  1, 1, 32'h00007F01, 1};
    vecs[4]  = '{"lhu_off0",   2'd1, 3'd2, 32'h00001000, 32'h80FF7F01, 32'h0,        5'd6,  1, 1, 32'h000080FF, 1};
    vecs[5]  = '{"lw",         2'd1, 3'd0, 32'h00001003, 32'h80FF7F01, 32'h0,        5'd7,  1, 1, 32'h80FF7F01, 1};
    vecs[6]  = '{"jal_r31",    2'd2, 3'd3, 32'h00000000, 32'h80FF7F01, 32'h00400010, 5'd31, 1, 1, 32'h00400010, 1};
    vecs[7]  = '{"jal_r0",     2'd2, 3'd0, 32'h00000000, 32'h80FF7F01, 32'h00400010, 5'd0,  1, 1, 32'h00400010, 0};
    vecs[8]  = '{"lb_off1",    2'd1, 3'd3, 32'h00001001, 32'h80FF7F01, 32'h0,        5'd9,  1, 1, 32'hFFFFFFFF, 1};
    vecs[9]  = '{"lbu_off3",   2'd1, 3'd4, 32'h00001003, 32'h80FF7F01, 32'h0,        5'd10, 1, 1, 32'h00000001, 1};
    vecs[10] = '{"lh_off0",    2'd1, 3'd1, 32'h00001000, 32'h80FF7F01, 32'h0,        5'd11, 1, 1, 32'hFFFF80FF, 1};
    vecs[11] = '{"lh_off3",    2'd1, 3'd1, 32'h00001003, 32'h80FF7F01, 32'h0,        5'd12, 1, 1, 32'h00007F01, 1};
    vecs[12] = '{"ltype_bad",  2'd1, 3'd6, 32'h00001001, 32'h80FF7F01, 32'h0,        5'd13, 1, 1, 32'h80FF7F01, 1};
    vecs[13] = '{"src_rsvd",   2'd3, 3'd3, 32'hA5A5_0002, 32'h80FF7F01, 32'hDEAD0000, 5'd14, 0, 1, 32'hA5A50002, 0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].dest, vecs[i].mtr, vecs[i].lt,
            vecs[i].alu, vecs[i].mem, vecs[i].link);
      tick();
      check({vecs[i].name, ".WriteData"}, WriteData, vecs[i].expData);
      check({vecs[i].name, ".WriteRegister"}, WriteRegister, vecs[i].dest);
      check({vecs[i].name, ".RegWrite"}, RegWrite, vecs[i].expRw);
      check({vecs[i].name, ".wb_valid"}, wb_valid, vecs[i].valid);
      check({vecs[i].name, ".fwd_RegWrite"}, fwd_RegWrite, vecs[i].expRw);
      check({vecs[i].name, ".fwd_WriteData"}, fwd_WriteData, vecs[i].expData);
      check({vecs[i].name, ".fwd_WriteRegister"}, fwd_WriteRegister, vecs[i].dest);
    end

    // ---------------- Asynchronous reset mid-stream ----------------
    drive(1, 1, 5'd5, 2'd0, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0);
    tick();
    check("midrst.pre_RegWrite", RegWrite, 1);
    #2 Reset = 1'b1;
    #1 checkAllZero("midrst");
    #2 Reset = 1'b0;

    // ---------------- Stall held for 3 cycles after a $9 write ----------------
    drive(1, 1, 5'd9, 2'd0, 3'd0, 32'hCAFE_0009, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("stall%0d.RegWrite", c), RegWrite, (c == 0) ? 1 : 0);
      check($sformatf("stall%0d.fwd_RegWrite", c), fwd_RegWrite, 1);
      check($sformatf("stall%0d.WriteData", c), WriteData, 32'hCAFE_0009);
      check($sformatf("stall%0d.WriteRegister", c), WriteRegister, 9);
      check($sformatf("stall%0d.wb_valid", c), wb_valid, 1);
      Stall = 1'b1;
      drive(1, 1, 5'd20, 2'd2, 3'd0, 32'h1111_1111, 32'h0, 32'h7777_0000 + c);
    end
`ifdef WB_COMMIT_COUNT_EN
    check("stall.commit_count", commit_count, 1);
`endif

    // ---------------- Flush together with Stall while holding a write ----------------
    Stall = 1'b0;
    drive(1, 1, 5'd10, 2'd0, 3'd0, 32'h0000_0A0A, 32'h0, 32'h0);
    tick();
    check("flush.capture_RegWrite", RegWrite, 1);
    Stall = 1'b1;
    tick();
    check("flush.stalled_fwd", fwd_RegWrite, 1);
    Flush = 1'b1;
    tick();
    check("flush.wb_valid", wb_valid, 0);
    check("flush.RegWrite", RegWrite, 0);
    check("flush.fwd_RegWrite", fwd_RegWrite, 0);
    check("flush.WriteData", WriteData, 0);
    check("flush.WriteRegister", WriteRegister, 0);
    Flush = 1'b0;
    Stall = 1'b0;
    drive(1, 1, 5'd11, 2'd1, 3'd4, 32'h0000_0002, 32'h1234_5678, 32'h0);
    tick();
    check("after_flush.RegWrite", RegWrite, 1);
    check("after_flush.wb_valid", wb_valid, 1);
    check("after_flush.WriteRegister", WriteRegister, 11);
    check("after_flush.WriteData", WriteData, 32'h0000_0056);
`ifdef WB_COMMIT_COUNT_EN
    check("after_flush.commit_count", commit_count, 2);
`endif

    // ---------------- Randomized run against the model ----------------
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    mValid = 0; mDest = 0; mData = 0; mWant = 0; mHeld = 0; mCount = 0;
    for (int n = 0; n < 400; n++) begin
      logic        v;
      logic        rw;
      logic [4:0]  dest;
      logic [1:0]  mtr;
      logic [2:0]  lt;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] link;
      v    = ($urandom_range(0, 4) != 0);
      rw   = ($urandom_range(0, 3) != 0);
      dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mtr  = 2'($urandom_range(0, 3));
      lt   = 3'($urandom_range(0, 7));
      alu  = $urandom;
      mem  = $urandom;
      link = $urandom;
      Flush = ($urandom_range(0, 9) == 0);
      Stall = ($urandom_range(0, 9) < 3);
      drive(v, rw, dest, mtr, lt, alu, mem, link);

      if (mWant && mHeld == 0) mCount++;
      if (Flush) begin
        mValid = 0; mDest = 0; mData = 0; mWant = 0; mHeld = 0;
      end else if (Stall) begin
        mHeld++;
      end else begin
        mValid = v;
        mDest  = dest;
        mData  = refData(mtr, lt, alu, mem, link);
        mWant  = v && rw && (dest != 0);
        mHeld  = 0;
      end

      tick();
      check($sformatf("rnd%0d.WriteData", n), WriteData, mData);
      check($sformatf("rnd%0d.WriteRegister", n), WriteRegister, mDest);
      check($sformatf("rnd%0d.RegWrite", n), RegWrite, mWant && mHeld == 0);
      check($sformatf("rnd%0d.wb_valid", n), wb_valid, mValid);
      check($sformatf("rnd%0d.fwd_RegWrite", n), fwd_RegWrite, mWant);
`ifdef WB_COMMIT_COUNT_EN
      check($sformatf("rnd%0d.commit_count", n), commit_count, mCount);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus write-back datapath for the 5-stage pipeline.
- It is the initiator that drives the register file write port (WriteRegister, WriteData, RegWrite); the register file captures on negedge Clk.
- It latches MEM-stage results on posedge Clk, selects and aligns write data, suppresses writes to $0, and commits each instruction's write exactly once under stall.
- It also exports forwarding copies for the hazard unit.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- Clk  input  1  pipeline clock; state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hold current MEM/WB contents.
- Flush  input  1  replace the captured instruction with a bubble.
- in_valid  input  1  MEM stage holds a real instruction.
- in_RegWrite  input  1  instruction writes a register.
- in_WriteRegister  input  5  destination register.
- in_MemToReg  input  2  source select: 00 ALU, 01 memory, 10 link, 11 reserved (treated as ALU).
- in_LoadType  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others = word.
- in_ALUResult  input  32  ALU result; bits [1:0] are the load byte offset.
- in_MemData  input  32  raw word read from data memory.
- in_LinkAddr  input  32  return address for jal/jalr.
- WriteRegister  output  5  to register file.
- WriteData  output  32  to register file.
- RegWrite  output  1  to register file.
- wb_valid  output  1  WB stage holds a real instruction.
- fwd_RegWrite  output  1  forwarding enable; equals RegWrite OR'd with the held-write condition during stall.
- fwd_WriteRegister  output  5  forwarding destination; mirrors WriteRegister.
- fwd_WriteData  output  32  forwarding data; mirrors WriteData.

Behaviour:
- Single always block on posedge Clk or posedge Reset.
- Reset clears all outputs and internal state to 0, including the committed flag. Reset asserted mid-operation discards the in-flight instruction immediately, asynchronously.
- Latency: one cycle. Inputs presented in cycle N appear on outputs after posedge N+1; the register file writes them on the negedge inside cycle N+1.
- Priority order: Reset > Flush > Stall > normal capture.
- Flush: captures a bubble. wb_valid=0 and RegWrite=0; WriteRegister and WriteData are cleared to 0.
- Normal capture:
  - wb_valid = in_valid.
  - RegWrite = in_valid & in_RegWrite & (in_WriteRegister != 0).
  - WriteRegister = in_WriteRegister.
  - WriteData = selected and aligned value.
  - committed flag is cleared.
- Stall:
  - WriteRegister, WriteData and wb_valid are held.
  - On the first stalled edge the committed flag is set and RegWrite drops to 0, so each instruction produces exactly one RegWrite-high cycle.
  - fwd_RegWrite stays high while the held instruction had a valid write, so consumers can still forward the value.
  - When Stall deasserts, normal capture resumes.
- Write to $0: RegWrite and fwd_RegWrite are 0. WriteData is still latched and visible.
- Load alignment (big-endian), applied only when in_MemToReg=01:
  - Byte: offset 0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0]. Signed types sign-extend, unsigned types zero-extend.
  - Halfword: ALUResult[1]=0 selects [31:16], 1 selects [15:0]. ALUResult[0] is ignored (misaligned access is not trapped).
  - Word: offset is ignored.
- in_MemToReg=10 passes in_LinkAddr unmodified; in_LoadType is ignored for ALU and link sources.
- Flush and Stall asserted together: Flush wins and the committed flag is cleared.

Optional Feature:
- Macro: WB_COMMIT_COUNT_EN.
- Defined:
  - Adds output commit_count [31:0].
  - Increments by 1 on every posedge where RegWrite is 1 in the cycle being left, i.e. once per committed register write.
  - Wraps 0xFFFFFFFF to 0.
  - Cleared by Reset; not affected by Flush.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset high mid-stream with RegWrite=1 -> all outputs 0 immediately, before the next edge; wb_valid=0.
- ALU write: in_MemToReg=00, ALUResult=0x12345678, dest=8 -> next cycle WriteData=0x12345678, WriteRegister=8, RegWrite=1 for exactly one cycle.
- Loads with MemData=0x80FF7F01:
  - lb at offset 0 -> 0xFFFFFF80.
  - lbu at offset 0 -> 0x00000080.
  - lh at offset 2 -> 0x00007F01.
  - lhu at offset 0 -> 0x000080FF.
  - lw -> 0x80FF7F01.
- jal: dest=31, MemToReg=10, LinkAddr=0x00400010 -> WriteData=0x00400010, RegWrite=1; the same instruction with dest=0 -> RegWrite=0, WriteData=0x00400010.
- Stall held 3 cycles after a dest=9 write -> RegWrite high exactly 1 cycle, fwd_RegWrite high all 4 cycles, WriteData stable; with WB_COMMIT_COUNT_EN, commit_count +1 only.
- Flush with Stall together while holding a valid write -> wb_valid=0, RegWrite=0, fwd_RegWrite=0 next cycle; the following valid input captures normally.
